// File: rtl/sha3_pkg.sv
// Shared SHA-3 constants and block-controller state encoding.
// Imported by the padder and the block sequencing control.
package sha3_pkg;

  localparam logic [7:0] PAD_FIRST = 8'h01;
  localparam logic [7:0] PAD_LAST  = 8'h80;
  localparam int RATE_WORDS_DEF    = 18;

  typedef enum logic [1:0] {
    FILL,
    PAD,
    FULL,
    DONE
  } state_t;

endpackage

// File: rtl/padder_block_ctrl_padder1.sv
// Word padder: keeps the valid leading bytes of the last word
// and places the first pad byte right after them.
module padder1
  import sha3_pkg::*;
(
  input  logic [23:0] in_hi,
  input  logic [1:0]  byte_num,
  output logic [31:0] out
);

  always_comb begin
    out = {PAD_FIRST, 24'h0};
    unique case (byte_num)
      2'd0: out = {PAD_FIRST, 24'h0};
      2'd1: out = {in_hi[23:16], PAD_FIRST, 16'h0};
      2'd2: out = {in_hi[23:8], PAD_FIRST, 8'h0};
      2'd3: out = {in_hi, PAD_FIRST};
    endcase
  end

endmodule

// File: rtl/padder_block_ctrl.sv
// Assembles rate-sized message blocks with SHA-3 padding and
// holds each completed block until the permutation acknowledges it.
module padder_block_ctrl
  import sha3_pkg::*;
#(
  parameter int RATE_WORDS = RATE_WORDS_DEF
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [31:0]              in,
  input  logic                     in_ready,
  input  logic                     is_last,
  input  logic [1:0]               byte_num,
  output logic                     in_accept,
  output logic                     buffer_full,
  output logic [RATE_WORDS*32-1:0] out,
  output logic                     out_ready,
  input  logic                     f_ack
);

  localparam int W  = RATE_WORDS * 32;
  localparam int CW = $clog2(RATE_WORDS + 1);
  localparam logic [CW-1:0] LAST_IDX = CW'(RATE_WORDS - 1);

  state_t          r_state;
  state_t          w_state_nxt;
  logic [CW-1:0]   r_count;
  logic            r_last_seen;
  logic [W-1:0]    r_out;
  logic [31:0]     w_pad1;
  logic [31:0]     w_word;
  logic            w_write;
  logic            w_fill_blk;
  logic            w_ack;

  padder1 u_padder1 (
    .in_hi    (in[31:8]),
    .byte_num (byte_num),
    .out      (w_pad1)
  );

  assign w_fill_blk = (r_count == LAST_IDX);
  assign w_ack      = (r_state == FULL) && f_ack;

  always_comb begin
    w_state_nxt = r_state;
    w_write     = 1'b0;
    w_word      = 32'h0;
    in_accept   = 1'b0;
    unique case (r_state)
      FILL: begin
        in_accept = in_ready;
        if (in_ready) begin
          w_write = 1'b1;
          w_word  = is_last ? w_pad1 : in;
          if (w_fill_blk) begin
            // final pad byte may share the word with the first pad byte
            if (is_last || r_last_seen)
              w_word = w_word | {24'h0, PAD_LAST};
            w_state_nxt = FULL;
          end else if (is_last) begin
            w_state_nxt = PAD;
          end
        end
      end
      PAD: begin
        w_write = 1'b1;
        if (w_fill_blk) begin
          w_word      = {24'h0, PAD_LAST};
          w_state_nxt = FULL;
        end
      end
      FULL: begin
        if (f_ack)
          w_state_nxt = r_last_seen ? DONE : FILL;
      end
      DONE: begin
        w_state_nxt = DONE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= FILL;
      r_count     <= '0;
      r_last_seen <= 1'b0;
      r_out       <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_write) begin
        r_out   <= {r_out[W-33:0], w_word};
        r_count <= r_count + 1'b1;
      end
      if (w_ack)
        r_count <= '0;
      if (in_accept && is_last)
        r_last_seen <= 1'b1;
    end
  end

  assign out         = r_out;
  assign buffer_full = (r_state == FULL);
  assign out_ready   = buffer_full;

endmodule

// File: tb/tb_padder_block_ctrl.sv
// Bench for padder_block_ctrl: directed and random messages checked
// against a padded-message reference built from plain word lists.
module tb_padder_block_ctrl;

  localparam int RW = 4;
  localparam int W  = RW * 32;

  logic          clk = 1'b0;
  logic          reset;
  logic [31:0]   in;
  logic          in_ready;
  logic          is_last;
  logic [1:0]    byte_num;
  logic          in_accept;
  logic          buffer_full;
  logic [W-1:0]  out;
  logic          out_ready;
  logic          f_ack;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  padder_block_ctrl #(.RATE_WORDS(RW)) dut (
    .clk         (clk),
    .reset       (reset),
    .in          (in),
    .in_ready    (in_ready),
    .is_last     (is_last),
    .byte_num    (byte_num),
    .in_accept   (in_accept),
    .buffer_full (buffer_full),
    .out         (out),
    .out_ready   (out_ready),
    .f_ack       (f_ack)
  );

  task automatic chk(input string tag, input logic [W-1:0] obs,
                     input logic [W-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference pad of the last word: keep bn leading bytes, then 0x01.
  function automatic logic [31:0] pad_word(input logic [31:0] d,
                                           input int bn);
    logic [31:0] r;
    r = 32'h0;
    for (int b = 0; b < 4; b++) begin
      if (b < bn)
        r[31-8*b -: 8] = d[31-8*b -: 8];
      else if (b == bn)
        r[31-8*b -: 8] = 8'h01;
    end
    return r;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; in_ready = 1'b0; f_ack = 1'b0; is_last = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst_out", out, '0);
    chk("rst_bf", W'(buffer_full), '0);
    chk("rst_or", W'(out_ready), '0);
    chk("rst_acc", W'(in_accept), '0);
  endtask

  // Feeds one message and checks every block; rnd adds random gaps.
  task automatic run_msg(input logic [31:0] msg[$], input int bn,
                         input bit rnd);
    logic [31:0]  words[$];
    logic [W-1:0] blks[$];
    logic [W-1:0] b;
    int n, idx, guard, full_cyc;
    bit acked;
    n = msg.size();
    for (int i = 0; i < n; i++)
      words.push_back(i == n - 1 ? pad_word(msg[i], bn) : msg[i]);
    while (words.size() % RW != 0)
      words.push_back(32'h0);
    words[words.size()-1] = words[words.size()-1] | 32'h80;
    for (int k = 0; k < words.size() / RW; k++) begin
      b = '0;
      for (int j = 0; j < RW; j++)
        b = {b[W-33:0], words[k*RW+j]};
      blks.push_back(b);
    end
    idx = 0; guard = 0; full_cyc = 0; acked = 0;
    while (blks.size() > 0 && guard < 500) begin
      @(negedge clk);
      guard++;
      in_ready = 1'b0; f_ack = 1'b0; is_last = 1'b0;
      if (acked) chk("bf_fall", W'(buffer_full), '0);
      acked = 0;
      if (buffer_full) begin
        chk("block", out, blks[0]);
        chk("out_ready", W'(out_ready), 1);
        full_cyc++;
        if (!rnd || $urandom_range(0, 1) == 1) begin
          in_ready = 1'b1;
          in = (idx < n) ? msg[idx] : $urandom;
          is_last = (idx == n - 1);
          byte_num = 2'(bn);
          #1;
          chk("acc_full", W'(in_accept), '0);
        end
        if (rnd ? ($urandom_range(0, 2) == 0) : (full_cyc >= 2)) begin
          f_ack = 1'b1;
          void'(blks.pop_front());
          acked = 1; full_cyc = 0;
        end
      end else if (idx < n) begin
        if (!rnd || $urandom_range(0, 3) != 0) begin
          in_ready = 1'b1;
          in = msg[idx];
          is_last = (idx == n - 1);
          byte_num = rnd ? 2'($urandom) : 2'(bn);
          if (idx == n - 1) byte_num = 2'(bn);
          #1;
          chk("acc_fill", W'(in_accept), 1);
          idx++;
        end
      end else begin
        in_ready = 1'b1;
        in = $urandom;
        #1;
        chk("acc_pad", W'(in_accept), '0);
      end
    end
    chk("timeout", W'(blks.size()), '0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      in_ready = 1'b1; f_ack = (c == 1); in = $urandom; is_last = 1'b0;
      #1;
      chk("done_acc", W'(in_accept), '0);
      chk("done_bf", W'(buffer_full), '0);
    end
    in_ready = 1'b0; f_ack = 1'b0;
  endtask

  initial begin
    logic [31:0] q[$];
    reset = 1'b1; in = '0; in_ready = 1'b0; is_last = 1'b0;
    byte_num = '0; f_ack = 1'b0;
    do_reset();

    q = {32'h11111111, 32'h22222222, 32'h33333333, 32'h44556677};
    run_msg(q, 2, 0);
    do_reset();
    q = {32'hAAAAAAAA, 32'h12345678};
    run_msg(q, 0, 0);
    do_reset();
    q = {32'h01020304, 32'h05060708, 32'h090A0B0C, 32'h0D0E0F10,
         32'h55555555, 32'h66666666};
    run_msg(q, 1, 0);
    do_reset();
    q = {32'hAABBCCDD};
    run_msg(q, 3, 0);
    do_reset();
    q = {32'hCAFEF00D, 32'hDEADBEEF, 32'h0BADC0DE, 32'h12345678};
    run_msg(q, 3, 0);

    // reset in the middle of padding
    do_reset();
    @(negedge clk);
    in_ready = 1'b1; in = 32'hAAAAAAAA; is_last = 1'b0;
    @(negedge clk);
    in = 32'h99999999; is_last = 1'b1; byte_num = 2'd0;
    @(negedge clk);
    in_ready = 1'b0; is_last = 1'b0; reset = 1'b1;
    @(negedge clk);
    reset = 1'b0; in_ready = 1'b1; in = 32'h77777777;
    #1;
    chk("pad_rst_out", out, '0);
    chk("pad_rst_bf", W'(buffer_full), '0);
    chk("pad_rst_acc", W'(in_accept), 1);
    in_ready = 1'b0;
    q = {32'h13572468, 32'h24681357, 32'hFFFFFFFF};
    run_msg(q, 1, 0);

    for (int t = 0; t < 30; t++) begin
      do_reset();
      q.delete();
      for (int i = 0; i < int'($urandom_range(1, 11)); i++)
        q.push_back($urandom);
      run_msg(q, int'($urandom_range(0, 3)), 1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
